muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised, multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It sits beside the combinational ALU in the execute stage. MULT/MULTU/DIV/DIVU run iteratively over WIDTH cycles, and the pipeline stalls on `w_busy`. It also serves MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO forwarding.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width. Must be ≥ 4 and even.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `w_start` in 1: request strobe; sampled only in IDLE.
- `w_op_code_6` in 6: function code from `isa_codes.v`. Legal values are `SPECIAL_MULT`, `SPECIAL_MULTU`, `SPECIAL_DIV`, `SPECIAL_DIVU`, `SPECIAL_MTHI`, `SPECIAL_MTLO`.
- `w_input1_x` in WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `w_input2_x` in WIDTH: rt operand (divisor / multiplier).
- `w_flush` in 1: synchronous cancel of an in-flight operation.
- `w_busy` out 1: high in RUN and FIX; the pipeline holds MFHI/MFLO and new requests while it is high.
- `w_done` out 1: one-cycle pulse in the cycle after HI/LO commit.
- `w_hi_x` out WIDTH: HI register.
- `w_lo_x` out WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `w_start`:
  - Mul/div opcode: latch operands, record signedness, load `count = WIDTH`, go to RUN.
  - Signed ops latch absolute values and the result signs: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - MTHI/MTLO: write HI or LO directly at that edge and stay in IDLE. No `w_busy`, no `w_done`.
  - Any other opcode: ignored.
- RUN, multiply: radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: radix-2 restoring division, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- RUN, general:
  - `count` decrements each cycle; at `count == 1` → FIX.
  - Operands and control are not re-sampled during RUN.
- FIX:
  - Apply two's-complement sign correction.
  - Commit: multiply → HI = product[2W-1:W], LO = product[W-1:0]; divide → LO = quotient, HI = remainder.
  - → IDLE. `w_done` is high the following cycle.
- Divide by zero (divisor == 0, detected at start): still runs full latency. Result is LO = all ones and HI = dividend (raw `w_input1_x`), for both signed and unsigned.
- Signed overflow (MIN / −1): LO = MIN, HI = 0. This falls out of the arithmetic; no special case is needed.
- `w_start` while busy: ignored. No queuing.
- `w_flush` in RUN or FIX: → IDLE next edge. HI/LO unchanged, no `w_done`. `w_flush` in IDLE has no effect. `w_flush` with `w_start` in IDLE: flush wins, request dropped.
- `reset`, including mid-operation: state IDLE, HI = 0, LO = 0, `w_busy` = 0, `w_done` = 0, counter and accumulators cleared. Operation lost.

## Timing
- Mul/div request accepted at edge E0. `w_busy` is high from after E0 through the FIX cycle (WIDTH+1 cycles).
- HI/LO update at edge E0+WIDTH+1. `w_done` is high for exactly the cycle after that edge.
- Back-to-back: a new `w_start` is accepted at the first edge where the state is IDLE, i.e. the `w_done` cycle. A start in that cycle is legal.
- MTHI/MTLO: zero-latency register write at the accepting edge; visible on `w_hi_x`/`w_lo_x` the next cycle.
- `w_hi_x`/`w_lo_x` are registered outputs and change only at commit, MTHI/MTLO, or reset.

## Structure
- Opcodes come from shared `isa_codes.v`. Add `SPECIAL_MTHI`/`SPECIAL_MTLO` there if absent.
- State encodings are localparams in the module. WIDTH-derived counter width is `$clog2(WIDTH+1)`.
- One natural sub-module: `muldiv_sign_fix`, combinational. It takes the absolute value of the inputs and negates the results conditionally, and is instantiated for entry and for FIX.

## Test plan
- Reset mid-RUN of a DIV, then release: HI = LO = 0, `w_busy` = 0, no `w_done`. A following MULTU 3×4 gives LO = 0xC, HI = 0.
- MULT −3 × 5 (WIDTH=32): after 33 busy cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, single `w_done` pulse. MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2: LO = 3, HI = 1.
- DIVU 100 / 0: LO = 0xFFFFFFFF, HI = 100. DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `w_start` pulsed mid-RUN with other operands: ignored, original result committed. `w_flush` at RUN cycle 10: IDLE next cycle, HI/LO hold prior values, no `w_done`.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles while idle: HI/LO visible one cycle later, `w_busy` never asserts. Repeat at WIDTH=16 with MULT −1 × −1: HI = 0, LO = 1, latency 17 busy cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: function codes, FSM state type and opcode helper for muldiv_unit
package muldiv_unit_pkg;
    localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
    localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
    localparam logic [5:0] SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
    localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic logic is_muldiv(input logic [5:0] op);
        return op inside {SPECIAL_MULT, SPECIAL_MULTU, SPECIAL_DIV, SPECIAL_DIVU};
    endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate (absolute value on entry, sign correction on commit)
// a_i: value, neg_i: negate when high, y_o: result
module muldiv_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic         neg_i,
    output logic [N-1:0] y_o
);
    assign y_o = neg_i ? -a_i : a_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers
// clock/reset: clock and async active-high reset; w_start/w_op_code_6/w_input1_x/w_input2_x: request;
// w_flush: cancel in-flight op; w_busy: RUN or FIX; w_done: pulse after commit; w_hi_x/w_lo_x: HI/LO
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_start,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_input1_x,
    input  logic [WIDTH-1:0] w_input2_x,
    input  logic             w_flush,
    output logic             w_busy,
    output logic             w_done,
    output logic [WIDTH-1:0] w_hi_x,
    output logic [WIDTH-1:0] w_lo_x
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q, opb_q, hi_q, lo_q;
    logic               is_div_q, neg_q, rem_neg_q, busy_q, done_q;

    // A zero divisor runs as an unsigned divide so the iteration naturally yields
    // quotient = all ones and remainder = the raw dividend.
    logic is_div, dz, sgn, s1, s2;
    assign is_div = w_op_code_6 inside {SPECIAL_DIV, SPECIAL_DIVU};
    assign dz     = is_div && w_input2_x == '0;
    assign sgn    = w_op_code_6 inside {SPECIAL_MULT, SPECIAL_DIV} && !dz;
    assign s1     = sgn & w_input1_x[WIDTH-1];
    assign s2     = sgn & w_input2_x[WIDTH-1];

    logic [WIDTH-1:0] abs1, abs2;
    muldiv_sign_fix #(.N(WIDTH)) u_abs1 (.a_i(w_input1_x), .neg_i(s1), .y_o(abs1));
    muldiv_sign_fix #(.N(WIDTH)) u_abs2 (.a_i(w_input2_x), .neg_i(s2), .y_o(abs2));

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_d;
    assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_d = {msum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc low half shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]   shl, trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_d, quot_d;
    assign shl    = {rem_q, acc_q[WIDTH-1]};
    assign trial  = shl - {1'b0, opb_q};
    assign qbit   = !trial[WIDTH];
    assign rem_d  = qbit ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
    assign quot_d = {acc_q[WIDTH-2:0], qbit};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    muldiv_sign_fix #(.N(2*WIDTH)) u_fix_prod (.a_i(acc_q), .neg_i(neg_q), .y_o(prod_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_fix_quot (.a_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .y_o(quot_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_fix_rem (.a_i(rem_q), .neg_i(rem_neg_q), .y_o(rem_fix));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (w_start && !w_flush) begin
                    if (is_muldiv(w_op_code_6)) begin
                        acc_q     <= {{WIDTH{1'b0}}, is_div ? abs1 : abs2};
                        opb_q     <= is_div ? abs2 : abs1;
                        rem_q     <= '0;
                        is_div_q  <= is_div;
                        neg_q     <= s1 ^ s2;
                        rem_neg_q <= s1;
                        count_q   <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else if (w_op_code_6 == SPECIAL_MTHI) begin
                        hi_q <= w_input1_x;
                    end else if (w_op_code_6 == SPECIAL_MTLO) begin
                        lo_q <= w_input1_x;
                    end
                end
                RUN: if (w_flush) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    if (is_div_q) begin
                        acc_q[WIDTH-1:0] <= quot_d;
                        rem_q            <= rem_d;
                    end else begin
                        acc_q <= mul_d;
                    end
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!w_flush) begin
                        hi_q   <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo_q   <= is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_busy = busy_q;
    assign w_done = done_q;
    assign w_hi_x = hi_q;
    assign w_lo_x = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=16
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, flush = 1'b0, start16 = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] a = '0, b = '0, hi, lo;
    logic [15:0] a16 = '0, b16 = '0, hi16, lo16;
    logic        busy, done, busy16, done16;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .w_start(start), .w_op_code_6(op),
        .w_input1_x(a), .w_input2_x(b), .w_flush(flush),
        .w_busy(busy), .w_done(done), .w_hi_x(hi), .w_lo_x(lo)
    );

    muldiv_unit #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .w_start(start16), .w_op_code_6(op),
        .w_input1_x(a16), .w_input2_x(b16), .w_flush(1'b0),
        .w_busy(busy16), .w_done(done16), .w_hi_x(hi16), .w_lo_x(lo16)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int poke);
        int n = 0;
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back('{eh, el});
        @(negedge clock);
        start = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (n == 1) check("done_low_in_run", {31'b0, done}, 0);
            start = (n == poke);
            if (n == poke) begin op = SPECIAL_MTLO; a = 32'hBAD0BAD0; b = 32'h1; end
            @(negedge clock);
        end
        start = 1'b0;
        check("busy_cycles", n, 33);
        check("done_pulse", {31'b0, done}, 1);
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        logic seen;
        vecs[0]  = '{SPECIAL_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{SPECIAL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{SPECIAL_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{SPECIAL_DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
        vecs[4]  = '{SPECIAL_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5]  = '{SPECIAL_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[6]  = '{SPECIAL_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[7]  = '{SPECIAL_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[8]  = '{SPECIAL_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{SPECIAL_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
        vecs[10] = '{SPECIAL_MULTU, 32'h12345678, 32'h10,       32'h1,        32'h23456780};

        repeat (2) @(negedge clock);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        reset = 1'b0;
        @(negedge clock);

        op = SPECIAL_MTHI; a = 32'h1234; start = 1'b1;
        @(negedge clock);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'b0, busy}, 0);
        op = SPECIAL_MTLO; a = 32'h5678;
        @(negedge clock);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_busy", {31'b0, busy}, 0);
        @(negedge clock);
        check("mt_no_done", {31'b0, done}, 0);

        op = SPECIAL_DIV; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("div_running", {31'b0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy}, 0);
        check("async_rst_hi", hi, 0);
        check("async_rst_lo", lo, 0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= done | busy;
        end
        check("no_activity_after_rst", {31'b0, seen}, 0);
        check("post_rst_hi", hi, 0);

        run_op(SPECIAL_MULTU, 32'd3, 32'd4, 32'd0, 32'hC, 0);
        for (int i = 0; i < 11; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);
        run_op(SPECIAL_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        op = SPECIAL_DIVU; a = 32'd50; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("flush_pre_busy", {31'b0, busy}, 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_idle", {31'b0, busy}, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen |= done | busy;
        end
        check("flush_no_done", {31'b0, seen}, 0);
        check("flush_hi", hi, 0);
        check("flush_lo", lo, 32'd42);

        flush = 1'b1; start = 1'b1; op = SPECIAL_MTHI; a = 32'hDEAD;
        @(negedge clock);
        flush = 1'b0; start = 1'b0;
        @(negedge clock);
        check("flush_start_hi", hi, 0);
        check("flush_start_busy", {31'b0, busy}, 0);

        op = SPECIAL_MULT; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        n = 0;
        while (busy16 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("w16_busy_cycles", n, 17);
        check("w16_done", {31'b0, done16}, 1);
        check("w16_hi", {16'b0, hi16}, 0);
        check("w16_lo", {16'b0, lo16}, 1);

        @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
